// File: rtl/recv_control.sv
// Receive-side segment acceptance: keeps the first good copy of each segment per aux round,
// drops redundant/stale/bad frames and reports round completion and loss statistics.
module recv_control #(
    parameter int unsigned MAX_SEGS = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk125MHz,
    input  logic             RST_N,
    input  logic [7:0]       redundancy,
    input  logic [15:0]      segment_num_max,
    input  logic             frame_valid,
    input  logic             crc_ok,
    input  logic [7:0]       rx_txid,
    input  logic [15:0]      rx_segment_num,
    input  logic [7:0]       rx_aux,
    output logic             busy,
    output logic             wr_en,
    output logic [15:0]      wr_segment,
    output logic [7:0]       wr_aux,
    output logic             round_done,
    output logic [7:0]       round_aux,
    output logic [15:0]      round_missing,
    output logic [CNT_W-1:0] dup_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int unsigned IDX_W = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, NEWROUND, ACCEPT} state_t;

    state_t                state, state_d;
    logic [7:0]            hdr_txid, hdr_txid_d;
    logic [15:0]           hdr_seg, hdr_seg_d;
    logic [7:0]            hdr_aux, hdr_aux_d;
    logic                  hdr_crc, hdr_crc_d;
    logic [MAX_SEGS-1:0]   bitmap, bitmap_d;
    logic [15:0]           rcvd, rcvd_d;
    logic [7:0]            cur_aux, cur_aux_d;
    logic                  have_round, have_round_d;
    logic                  closed, closed_d;
    logic                  busy_d, wr_en_d, round_done_d;
    logic [15:0]           wr_segment_d, round_missing_d;
    logic [7:0]            wr_aux_d, round_aux_d;
    logic [CNT_W-1:0]      dup_count_d, err_count_d;
    logic [1:0]            err_inc, dup_inc;
    logic [IDX_W-1:0]      seg_idx;
    logic                  hdr_bad;

    // Saturating counter add; increment is at most 2 (CHECK error plus overrun in one cycle)
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, v} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk125MHz or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d         = state;
        hdr_txid_d      = hdr_txid;
        hdr_seg_d       = hdr_seg;
        hdr_aux_d       = hdr_aux;
        hdr_crc_d       = hdr_crc;
        bitmap_d        = bitmap;
        rcvd_d          = rcvd;
        cur_aux_d       = cur_aux;
        have_round_d    = have_round;
        closed_d        = closed;
        busy_d          = busy;
        wr_en_d         = 1'b0;
        wr_segment_d    = wr_segment;
        wr_aux_d        = wr_aux;
        round_done_d    = 1'b0;
        round_aux_d     = round_aux;
        round_missing_d = round_missing;
        err_inc         = 2'd0;
        dup_inc         = 2'd0;
        seg_idx         = hdr_seg[IDX_W-1:0];
        hdr_bad         = !hdr_crc || (hdr_seg >= segment_num_max) ||
                          (32'(hdr_seg) >= MAX_SEGS) || (hdr_txid == 8'd0) ||
                          (hdr_txid > redundancy);

        if (frame_valid && busy) err_inc = err_inc + 2'd1;

        case (state)
            IDLE: begin
                if (frame_valid) begin
                    hdr_txid_d = rx_txid;
                    hdr_seg_d  = rx_segment_num;
                    hdr_aux_d  = rx_aux;
                    hdr_crc_d  = crc_ok;
                    busy_d     = 1'b1;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (hdr_bad) begin
                    err_inc = err_inc + 2'd1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!have_round) begin
                    cur_aux_d    = hdr_aux;
                    have_round_d = 1'b1;
                    bitmap_d     = '0;
                    rcvd_d       = 16'd0;
                    closed_d     = 1'b0;
                    state_d      = ACCEPT;
                end else if (hdr_aux == cur_aux - 8'd1) begin
                    dup_inc = 2'd1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (hdr_aux != cur_aux) begin
                    state_d = NEWROUND;
                end else begin
                    state_d = ACCEPT;
                end
            end
            NEWROUND: begin
                // A round already closed by completion was reported at its last write
                if (!closed) begin
                    round_done_d    = 1'b1;
                    round_aux_d     = cur_aux;
                    round_missing_d = segment_num_max - rcvd;
                end
                bitmap_d  = '0;
                rcvd_d    = 16'd0;
                closed_d  = 1'b0;
                cur_aux_d = hdr_aux;
                state_d   = ACCEPT;
            end
            ACCEPT: begin
                if (bitmap[seg_idx] || closed) begin
                    dup_inc = 2'd1;
                end else begin
                    wr_en_d           = 1'b1;
                    wr_segment_d      = hdr_seg;
                    wr_aux_d          = cur_aux;
                    bitmap_d[seg_idx] = 1'b1;
                    rcvd_d            = rcvd + 16'd1;
                    if (rcvd + 16'd1 == segment_num_max) begin
                        round_done_d    = 1'b1;
                        round_aux_d     = cur_aux;
                        round_missing_d = 16'd0;
                        closed_d        = 1'b1;
                    end
                end
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        dup_count_d = sat_add(dup_count, dup_inc);
        err_count_d = sat_add(err_count, err_inc);
    end

    always_ff @(posedge clk125MHz or negedge RST_N) begin
        if (!RST_N) begin
            hdr_txid      <= 8'd0;
            hdr_seg       <= 16'd0;
            hdr_aux       <= 8'd0;
            hdr_crc       <= 1'b0;
            bitmap        <= '0;
            rcvd          <= 16'd0;
            cur_aux       <= 8'd0;
            have_round    <= 1'b0;
            closed        <= 1'b0;
            busy          <= 1'b0;
            wr_en         <= 1'b0;
            wr_segment    <= 16'd0;
            wr_aux        <= 8'd0;
            round_done    <= 1'b0;
            round_aux     <= 8'd0;
            round_missing <= 16'd0;
            dup_count     <= '0;
            err_count     <= '0;
        end else begin
            hdr_txid      <= hdr_txid_d;
            hdr_seg       <= hdr_seg_d;
            hdr_aux       <= hdr_aux_d;
            hdr_crc       <= hdr_crc_d;
            bitmap        <= bitmap_d;
            rcvd          <= rcvd_d;
            cur_aux       <= cur_aux_d;
            have_round    <= have_round_d;
            closed        <= closed_d;
            busy          <= busy_d;
            wr_en         <= wr_en_d;
            wr_segment    <= wr_segment_d;
            wr_aux        <= wr_aux_d;
            round_done    <= round_done_d;
            round_aux     <= round_aux_d;
            round_missing <= round_missing_d;
            dup_count     <= dup_count_d;
            err_count     <= err_count_d;
        end
    end

endmodule

// File: tb/tb_recv_control.sv
// Directed bench for recv_control: acceptance, duplicates, errors, round rollover, overrun and reset.
module tb_recv_control;
    logic        clk125MHz;
    logic        RST_N;
    logic [7:0]  redundancy;
    logic [15:0] segment_num_max;
    logic        frame_valid;
    logic        crc_ok;
    logic [7:0]  rx_txid;
    logic [15:0] rx_segment_num;
    logic [7:0]  rx_aux;
    logic        busy;
    logic        wr_en;
    logic [15:0] wr_segment;
    logic [7:0]  wr_aux;
    logic        round_done;
    logic [7:0]  round_aux;
    logic [15:0] round_missing;
    logic [15:0] dup_count;
    logic [15:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations of the most recent send(): counts and cycle index after the sampling edge
    int          o_wr_n, o_wr_at, o_rd_n, o_rd_at;
    logic [15:0] o_wr_seg, o_rd_miss;
    logic [7:0]  o_wr_aux, o_rd_aux;
    logic [5:0]  o_busy;

    recv_control dut (
        .clk125MHz      (clk125MHz),
        .RST_N          (RST_N),
        .redundancy     (redundancy),
        .segment_num_max(segment_num_max),
        .frame_valid    (frame_valid),
        .crc_ok         (crc_ok),
        .rx_txid        (rx_txid),
        .rx_segment_num (rx_segment_num),
        .rx_aux         (rx_aux),
        .busy           (busy),
        .wr_en          (wr_en),
        .wr_segment     (wr_segment),
        .wr_aux         (wr_aux),
        .round_done     (round_done),
        .round_aux      (round_aux),
        .round_missing  (round_missing),
        .dup_count      (dup_count),
        .err_count      (err_count)
    );

    initial clk125MHz = 1'b0;
    always #4 clk125MHz = ~clk125MHz;

    task automatic do_reset(input logic [7:0] red, input logic [15:0] snm);
        RST_N           = 1'b0;
        frame_valid     = 1'b0;
        crc_ok          = 1'b0;
        rx_txid         = 8'd0;
        rx_segment_num  = 16'd0;
        rx_aux          = 8'd0;
        redundancy      = red;
        segment_num_max = snm;
        repeat (2) @(posedge clk125MHz);
        @(negedge clk125MHz);
        RST_N = 1'b1;
    endtask

    // One-cycle frame pulse, then observe six cycles (index i = negedge after the i-th edge from sampling)
    task automatic send(input logic [7:0] txid, input logic [15:0] seg, input logic [7:0] aux, input logic crc);
        @(posedge clk125MHz); #1;
        frame_valid    = 1'b1;
        rx_txid        = txid;
        rx_segment_num = seg;
        rx_aux         = aux;
        crc_ok         = crc;
        o_wr_n = 0; o_wr_at = -1; o_rd_n = 0; o_rd_at = -1; o_busy = '0;
        o_wr_seg = '0; o_wr_aux = '0; o_rd_aux = '0; o_rd_miss = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk125MHz); #1;
            if (i == 0) frame_valid = 1'b0;
            @(negedge clk125MHz);
            o_busy[i] = busy;
            if (wr_en) begin
                if (o_wr_n == 0) begin o_wr_at = i; o_wr_seg = wr_segment; o_wr_aux = wr_aux; end
                o_wr_n++;
            end
            if (round_done) begin
                if (o_rd_n == 0) begin o_rd_at = i; o_rd_aux = round_aux; o_rd_miss = round_missing; end
                o_rd_n++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset(8'd3, 16'd4);
        @(negedge clk125MHz);
        n_cmp++;
        if ({busy, wr_en, wr_segment, wr_aux, round_done, round_aux, round_missing, dup_count, err_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b wr_en=%b wr_seg=%0d wr_aux=%0d rd=%b rd_aux=%0d miss=%0d dup=%0d err=%0d, required all 0",
                     busy, wr_en, wr_segment, wr_aux, round_done, round_aux, round_missing, dup_count, err_count);
        end
    endtask

    task automatic test_full_round();
        int wr_total = 0;
        int rd_total = 0;
        do_reset(8'd3, 16'd4);
        for (int s = 0; s < 4; s++) begin
            for (int t = 1; t <= 3; t++) begin
                send(8'(t), 16'(s), 8'd0, 1'b1);
                wr_total += o_wr_n;
                rd_total += o_rd_n;
                if (t == 1) begin
                    n_cmp++;
                    if (o_wr_n !== 1 || o_wr_at !== 2 || o_wr_seg !== 16'(s) || o_wr_aux !== 8'd0) begin
                        n_bad++;
                        $display("FAIL full_accept seg%0d: n=%0d at=%0d seg=%0d aux=%0d, required n=1 at=2 seg=%0d aux=0",
                                 s, o_wr_n, o_wr_at, o_wr_seg, o_wr_aux, s);
                    end
                end
                if (s == 0 && t == 1) begin
                    n_cmp++;
                    if (o_busy !== 6'b000011) begin
                        n_bad++;
                        $display("FAIL full_busy: busy trace=%b, required 000011", o_busy);
                    end
                end
                if (s == 3 && t == 1) begin
                    n_cmp++;
                    if (o_rd_n !== 1 || o_rd_at !== 2 || o_rd_aux !== 8'd0 || o_rd_miss !== 16'd0) begin
                        n_bad++;
                        $display("FAIL full_round_done: n=%0d at=%0d aux=%0d miss=%0d, required n=1 at=2 aux=0 miss=0",
                                 o_rd_n, o_rd_at, o_rd_aux, o_rd_miss);
                    end
                end
            end
        end
        n_cmp++;
        if (wr_total !== 4 || rd_total !== 1) begin
            n_bad++;
            $display("FAIL full_totals: wr=%0d rd=%0d, required wr=4 rd=1", wr_total, rd_total);
        end
        n_cmp++;
        if (dup_count !== 16'd8 || err_count !== 16'd0) begin
            n_bad++;
            $display("FAIL full_counters: dup=%0d err=%0d, required dup=8 err=0", dup_count, err_count);
        end
        // Completed round: next aux opens a round without a second round_done
        send(8'd1, 16'd0, 8'd1, 1'b1);
        n_cmp++;
        if (o_rd_n !== 0 || o_wr_n !== 1 || o_wr_at !== 3 || o_wr_aux !== 8'd1) begin
            n_bad++;
            $display("FAIL full_next_round: rd=%0d wr=%0d at=%0d aux=%0d, required rd=0 wr=1 at=3 aux=1",
                     o_rd_n, o_wr_n, o_wr_at, o_wr_aux);
        end
    endtask

    task automatic test_missing_segment();
        logic [15:0] segs [3] = '{16'd0, 16'd1, 16'd3};
        do_reset(8'd3, 16'd4);
        for (int k = 0; k < 3; k++)
            for (int t = 1; t <= 3; t++)
                send(8'(t), segs[k], 8'd5, 1'b1);
        n_cmp++;
        if (dup_count !== 16'd6) begin
            n_bad++;
            $display("FAIL missing_dup: dup=%0d, required 6", dup_count);
        end
        send(8'd1, 16'd0, 8'd6, 1'b1);
        n_cmp++;
        if (o_rd_n !== 1 || o_rd_at !== 2 || o_rd_aux !== 8'd5 || o_rd_miss !== 16'd1) begin
            n_bad++;
            $display("FAIL missing_round_done: n=%0d at=%0d aux=%0d miss=%0d, required n=1 at=2 aux=5 miss=1",
                     o_rd_n, o_rd_at, o_rd_aux, o_rd_miss);
        end
        n_cmp++;
        if (o_wr_n !== 1 || o_wr_at !== 3 || o_wr_aux !== 8'd6 || o_wr_seg !== 16'd0 || o_busy !== 6'b000111) begin
            n_bad++;
            $display("FAIL missing_new_write: n=%0d at=%0d aux=%0d seg=%0d busy=%b, required n=1 at=3 aux=6 seg=0 busy=000111",
                     o_wr_n, o_wr_at, o_wr_aux, o_wr_seg, o_busy);
        end
    endtask

    task automatic test_errors();
        logic [7:0]  e_txid [4] = '{8'd1, 8'd1, 8'd0, 8'd4};
        logic [15:0] e_seg  [4] = '{16'd0, 16'd4, 16'd0, 16'd0};
        logic        e_crc  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_reset(8'd3, 16'd4);
        send(8'd1, 16'd1, 8'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            send(e_txid[k], e_seg[k], 8'd0, e_crc[k]);
            n_cmp++;
            if (o_wr_n !== 0 || o_rd_n !== 0 || o_busy !== 6'b000001) begin
                n_bad++;
                $display("FAIL error_frame%0d: wr=%0d rd=%0d busy=%b, required wr=0 rd=0 busy=000001",
                         k, o_wr_n, o_rd_n, o_busy);
            end
        end
        n_cmp++;
        if (err_count !== 16'd4 || dup_count !== 16'd0) begin
            n_bad++;
            $display("FAIL error_counters: err=%0d dup=%0d, required err=4 dup=0", err_count, dup_count);
        end
        send(8'd1, 16'd0, 8'd0, 1'b1);
        n_cmp++;
        if (o_wr_n !== 1 || o_wr_seg !== 16'd0) begin
            n_bad++;
            $display("FAIL error_bitmap_seg0: wr=%0d seg=%0d, required wr=1 seg=0", o_wr_n, o_wr_seg);
        end
        send(8'd3, 16'd3, 8'd0, 1'b1);
        n_cmp++;
        if (o_wr_n !== 1 || o_wr_seg !== 16'd3) begin
            n_bad++;
            $display("FAIL error_edge_legal: wr=%0d seg=%0d, required wr=1 seg=3", o_wr_n, o_wr_seg);
        end
        send(8'd2, 16'd1, 8'd0, 1'b1);
        n_cmp++;
        if (o_wr_n !== 0 || dup_count !== 16'd1) begin
            n_bad++;
            $display("FAIL error_bitmap_seg1: wr=%0d dup=%0d, required wr=0 dup=1", o_wr_n, dup_count);
        end
        // Bitmap depth bound with a larger round
        do_reset(8'd3, 16'd100);
        send(8'd1, 16'd64, 8'd0, 1'b1);
        send(8'd1, 16'd63, 8'd0, 1'b1);
        n_cmp++;
        if (o_wr_n !== 1 || o_wr_seg !== 16'd63 || err_count !== 16'd1) begin
            n_bad++;
            $display("FAIL error_max_segs: wr=%0d seg=%0d err=%0d, required wr=1 seg=63 err=1", o_wr_n, o_wr_seg, err_count);
        end
        do_reset(8'd3, 16'd0);
        send(8'd1, 16'd0, 8'd0, 1'b1);
        n_cmp++;
        if (o_wr_n !== 0 || err_count !== 16'd1) begin
            n_bad++;
            $display("FAIL error_zero_segs: wr=%0d err=%0d, required wr=0 err=1", o_wr_n, err_count);
        end
    endtask

    task automatic test_stale_wrap();
        do_reset(8'd3, 16'd4);
        send(8'd1, 16'd0, 8'd0, 1'b1);
        send(8'd1, 16'd1, 8'd255, 1'b1);
        n_cmp++;
        if (o_wr_n !== 0 || o_rd_n !== 0 || dup_count !== 16'd1) begin
            n_bad++;
            $display("FAIL stale_drop: wr=%0d rd=%0d dup=%0d, required wr=0 rd=0 dup=1", o_wr_n, o_rd_n, dup_count);
        end
        do_reset(8'd3, 16'd4);
        send(8'd1, 16'd0, 8'd255, 1'b1);
        n_cmp++;
        if (o_wr_n !== 1 || o_wr_at !== 2 || o_wr_aux !== 8'd255) begin
            n_bad++;
            $display("FAIL wrap_first: wr=%0d at=%0d aux=%0d, required wr=1 at=2 aux=255", o_wr_n, o_wr_at, o_wr_aux);
        end
        send(8'd1, 16'd0, 8'd0, 1'b1);
        n_cmp++;
        if (o_rd_n !== 1 || o_rd_at !== 2 || o_rd_aux !== 8'd255 || o_rd_miss !== 16'd3 ||
            o_wr_n !== 1 || o_wr_at !== 3 || o_wr_aux !== 8'd0) begin
            n_bad++;
            $display("FAIL wrap_round: rd=%0d at=%0d aux=%0d miss=%0d wr=%0d at=%0d aux=%0d, required rd=1 at=2 aux=255 miss=3 wr=1 at=3 aux=0",
                     o_rd_n, o_rd_at, o_rd_aux, o_rd_miss, o_wr_n, o_wr_at, o_wr_aux);
        end
    endtask

    task automatic test_back_to_back();
        int          wr_n = 0;
        logic [15:0] seg  = 16'hFFFF;
        do_reset(8'd3, 16'd4);
        @(posedge clk125MHz); #1;
        frame_valid = 1'b1; crc_ok = 1'b1; rx_txid = 8'd1; rx_segment_num = 16'd2; rx_aux = 8'd7;
        @(posedge clk125MHz); #1;
        rx_txid = 8'd2; rx_segment_num = 16'd3;
        @(posedge clk125MHz); #1;
        frame_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk125MHz);
            if (wr_en) begin wr_n++; seg = wr_segment; end
        end
        n_cmp++;
        if (wr_n !== 1 || seg !== 16'd2 || err_count !== 16'd1 || dup_count !== 16'd0) begin
            n_bad++;
            $display("FAIL overrun: wr=%0d seg=%0d err=%0d dup=%0d, required wr=1 seg=2 err=1 dup=0",
                     wr_n, seg, err_count, dup_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        int wr_n = 0;
        do_reset(8'd3, 16'd4);
        send(8'd1, 16'd0, 8'd3, 1'b1);
        send(8'd2, 16'd0, 8'd3, 1'b1);
        @(posedge clk125MHz); #1;
        frame_valid = 1'b1; crc_ok = 1'b1; rx_txid = 8'd1; rx_segment_num = 16'd1; rx_aux = 8'd3;
        @(posedge clk125MHz); #1;
        frame_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || dup_count !== 16'd1) begin
            n_bad++;
            $display("FAIL midreset_pre: busy=%b dup=%0d, required busy=1 dup=1", busy, dup_count);
        end
        RST_N = 1'b0;
        #1;
        n_cmp++;
        if ({busy, wr_en, wr_segment, wr_aux, round_done, round_aux, round_missing, dup_count, err_count} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: busy=%b wr_en=%b dup=%0d wr_seg=%0d wr_aux=%0d, required all 0",
                     busy, wr_en, dup_count, wr_segment, wr_aux);
        end
        @(negedge clk125MHz);
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk125MHz);
            if (wr_en) wr_n++;
        end
        n_cmp++;
        if (wr_n !== 0) begin
            n_bad++;
            $display("FAIL midreset_no_write: wr=%0d, required 0", wr_n);
        end
        send(8'd1, 16'd2, 8'd9, 1'b1);
        n_cmp++;
        if (o_wr_n !== 1 || o_wr_at !== 2 || o_wr_aux !== 8'd9 || o_wr_seg !== 16'd2 || o_rd_n !== 0) begin
            n_bad++;
            $display("FAIL midreset_first: wr=%0d at=%0d aux=%0d seg=%0d rd=%0d, required wr=1 at=2 aux=9 seg=2 rd=0",
                     o_wr_n, o_wr_at, o_wr_aux, o_wr_seg, o_rd_n);
        end
    endtask

    initial begin
        test_reset();
        test_full_round();
        test_missing_segment();
        test_errors();
        test_stale_wrap();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/recv_control.md
Name: recv_control

Overview:
- Receive-side counterpart of the frame send controller.
- Consumes the parsed header (txid, segment_num, aux) of each received frame from the RX frame parser.
- Accepts the first good copy of each segment per aux round and drops redundant copies.
- Drives the segment-RAM write strobe and reports per-round completion and loss statistics.

Parameters:
MAX_SEGS, 64, bitmap depth; the highest legal segment index is MAX_SEGS-1
CNT_W, 16, width of the statistic counters

Ports:
clk125MHz  in  1  system clock, 125 MHz
RST_N  in  1  asynchronous active-low reset
redundancy  in  8  copies sent per segment; legal txid range is 1..redundancy
segment_num_max  in  16  segments per round; legal segment_num range is 0..segment_num_max-1
frame_valid  in  1  one-cycle pulse; header fields and crc_ok are valid in this cycle
crc_ok  in  1  FCS check result of the frame
rx_txid  in  8  copy index of the frame
rx_segment_num  in  16  segment index of the frame
rx_aux  in  8  round counter of the frame
busy  out  1  high while a frame is being evaluated
wr_en  out  1  one-cycle pulse; write the accepted payload to segment RAM
wr_segment  out  16  segment index for wr_en
wr_aux  out  8  round for wr_en
round_done  out  1  one-cycle pulse; a round has been closed
round_aux  out  8  aux of the closed round
round_missing  out  16  segment_num_max minus segments received in the closed round
dup_count  out  CNT_W  count of dropped duplicate and stale frames, saturating
err_count  out  CNT_W  count of dropped bad frames (CRC, range, overrun), saturating

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0; state IDLE; bitmap cleared; rcvd=0; cur_aux=0; have_round=0; closed=0.
- FSM states: IDLE, CHECK, NEWROUND, ACCEPT.
- IDLE: on frame_valid, latch the header and crc_ok; busy<=1; go to CHECK.
- Overrun: frame_valid while busy=1 is dropped and increments err_count. It does not disturb the frame in flight.
- CHECK (precedence top-down):
  - Error: crc_ok=0, seg>=segment_num_max, seg>=MAX_SEGS, txid==0, or txid>redundancy. Action: err_count++, go to IDLE.
  - First frame after reset (have_round=0): cur_aux<=rx_aux, have_round<=1, bitmap and rcvd cleared; go to ACCEPT.
  - Stale frame, rx_aux==cur_aux-1 mod 256: dup_count++, go to IDLE.
  - New round, rx_aux!=cur_aux: go to NEWROUND.
  - Otherwise: go to ACCEPT.
- NEWROUND:
  - If closed=0: pulse round_done with round_aux=cur_aux and round_missing=segment_num_max-rcvd.
  - Always: clear bitmap, rcvd<=0, closed<=0, cur_aux<=rx_aux; go to ACCEPT.
- ACCEPT:
  - If bitmap[seg]=1 or closed=1: dup_count++.
  - Else: wr_en pulse, wr_segment<=seg, wr_aux<=cur_aux, bitmap[seg]<=1, rcvd++.
  - If this write makes rcvd==segment_num_max: pulse round_done in the same cycle as wr_en, with round_missing=0; closed<=1.
  - Go to IDLE; busy<=0.
- Latency: wr_en is registered and appears 2 cycles after frame_valid, or 3 cycles when a new round is opened.
  - busy is high from the cycle after frame_valid until the return to IDLE.
  - Minimum frame spacing is therefore 3 or 4 cycles; real frames are far longer.
- Arithmetic:
  - aux compare is modulo 256; wrap 255->0 is a normal new round.
  - round_missing is 16-bit unsigned.
  - Counters saturate at 2^CNT_W-1.
- A round that closed by completion emits no second round_done when the next aux arrives.
- Reset mid-frame aborts the frame; no wr_en is issued for it.
- redundancy and segment_num_max are treated as static between resets.
- segment_num_max=0: every frame is an error.

Test Plan:
- redundancy=3, segment_num_max=4, aux=0, each segment sent as txid 1,2,3 -> wr_en exactly 4 times (segments 0..3), dup_count=8, round_done once with round_missing=0, wr_en 2 cycles after each accepted frame_valid.
- Round aux=5 with segment 2 never sent (all copies of segs 0,1,3), then a frame with aux=6 -> round_done with round_aux=5, round_missing=1, cycle before the aux=6 wr_en.
- Errors: crc_ok=0; seg=4 with segment_num_max=4; txid=0; txid=4 with redundancy=3 -> err_count=4, no wr_en, bitmap unchanged.
- Stale and wrap: cur_aux=0, frame with aux=255 -> dup_count++, no round_done; cur_aux=255, frame with aux=0 -> round_done with round_aux=255, then wr_en with wr_aux=0.
- Overrun: two frame_valid pulses 1 cycle apart -> first accepted, err_count=1.
- Reset: assert RST_N low during CHECK -> all outputs 0 immediately, no wr_en; next frame is treated as first and sets cur_aux.
